// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser plus per-key stability counter for
// active-low pushbuttons. It produces a glitch-free level bus for a PIO
// in_port and one-cycle press/release strobes.
module key_debounce #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_clean,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  // Count value reached on the last cycle of a full stable window.
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_t;

  // Elaboration-time guard on the parameter ranges.
  if (NUM_KEYS < 1 || NUM_KEYS > 32) begin : g_bad_num_keys
    $error("key_debounce: NUM_KEYS must be in 1..32");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_window
    $error("key_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;

  // Two-flop synchroniser; both stages park at "released" during reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             clean;
    logic             clean_next;
    logic             press;
    logic             press_next;
    logic             release_q;
    logic             release_next;
    logic             differ;
    logic             terminal;

    assign differ   = sync2[i] ^ clean;
    assign terminal = (cnt == TERM_CNT);

    // Next-state logic: any return to equality restarts the window; a
    // full window of disagreement adopts the synchronised level.
    always_comb begin
      state_next   = state;
      cnt_next     = '0;
      clean_next   = clean;
      press_next   = 1'b0;
      release_next = 1'b0;
      unique case (state)
        ST_STABLE: begin
          if (differ) begin
            state_next = ST_COUNTING;
            cnt_next   = CNT_W'(1);
          end
        end
        ST_COUNTING: begin
          if (!differ) begin
            state_next = ST_STABLE;
          end else if (terminal) begin
            state_next   = ST_STABLE;
            clean_next   = sync2[i];
            press_next   = ~sync2[i];
            release_next = sync2[i];
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_next = ST_STABLE;
        end
      endcase
    end

    // State, counter, level and strobe registers; reset overrides any count.
    always_ff @(posedge clk) begin
      if (reset) begin
        state     <= ST_STABLE;
        cnt       <= '0;
        clean     <= 1'b1;
        press     <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_next;
        cnt       <= cnt_next;
        clean     <= clean_next;
        press     <= press_next;
        release_q <= release_next;
      end
    end

    assign key_clean[i]   = clean;
    assign key_press[i]   = press;
    assign key_release[i] = release_q;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Conditions raw mechanical pushbutton inputs before they reach the KEYs parallel-input port of the Nios system. Each key is synchronised into the `clk` domain and debounced with a per-key stability counter. The block drives a glitch-free active-low level bus straight into the PIO `in_port`, plus one-cycle press/release strobes for hardware consumers that bypass the processor. It sits between the board pins and the KEYs PIO.

## Interface
- `NUM_KEYS`, 2: number of independent keys. Range 1..32.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required before accepting a new level. At 50 MHz this is 10 ms. Minimum 2.
- `CNT_W`, $clog2(DEBOUNCE_CYCLES): counter width, derived. It is not overridden.

Ports:
- `clk`  in  1: system clock; one clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `key_raw`  in  NUM_KEYS: asynchronous raw pin levels; active-low (0 = pressed).
- `key_clean`  out  NUM_KEYS: debounced level, active-low; connects to PIO `in_port`.
- `key_press`  out  NUM_KEYS: one-cycle strobe when `key_clean[i]` goes 1→0.
- `key_release`  out  NUM_KEYS: one-cycle strobe when `key_clean[i]` goes 0→1.

## Operation
- **Synchroniser:** two-flop chain per key, `sync1` ← `key_raw`, then `sync2` ← `sync1`. Only `sync2` is used downstream. Both flops reset to all-ones (released).
- **Per-key state machine:** two states, evaluated independently for each key `i`.
  - STABLE (`sync2[i] == key_clean[i]`): `cnt[i]` is held at 0.
  - COUNTING (`sync2[i] != key_clean[i]`): `cnt[i]` increments by 1 each cycle.
  - Return to equality before terminal count: go back to STABLE and clear `cnt[i]` to 0. Bounces therefore restart the window.
  - Terminal count (`cnt[i] == DEBOUNCE_CYCLES-1` while still unequal): on the next edge, `key_clean[i]` ← `sync2[i]`, `cnt[i]` ← 0, and the matching strobe asserts for exactly that one cycle.
- **Strobes:**
  - Registered; high in the same cycle that the new `key_clean` value is visible.
  - `key_press[i]` and `key_release[i]` are never high together.
  - The minimum spacing between two strobes on one key is `DEBOUNCE_CYCLES` cycles.
- **Counter arithmetic:**
  - Unsigned, `CNT_W` bits.
  - It never exceeds `DEBOUNCE_CYCLES-1`, so no wrap-around is possible.
- **Key independence:** keys share no state. Simultaneous transitions on several keys are each debounced independently and may strobe in the same cycle.
- **Reset values** (reset wins over all other activity, including mid-count):
  - `key_clean` = all ones.
  - `key_press` = 0, `key_release` = 0.
  - All `cnt` = 0, `sync1` = `sync2` = all ones.
  - A key held pressed through reset is accepted `DEBOUNCE_CYCLES` cycles after `sync2` shows 0. A press strobe is then emitted.

## Timing
- Raw level change sampled at edge E0 (into `sync1`). It reaches `sync2` at E1. COUNTING begins in the cycle after E1.
- For a clean, bounce-free change, `key_clean` and the strobe update at edge E1 + `DEBOUNCE_CYCLES`. Total latency is `DEBOUNCE_CYCLES`+2 edges from sampling.
- Strobe width is exactly 1 cycle.
- Glitch rejection:
  - Any raw pulse shorter than `DEBOUNCE_CYCLES` cycles at `sync2` never changes `key_clean`.
  - A pulse lasting exactly `DEBOUNCE_CYCLES` cycles is accepted.
- The downstream PIO double-registers `in_port` and detects falling edges. It therefore sees each accepted press as exactly one edge.
- There are no combinational paths from inputs to outputs.

## Test plan
Bench uses NUM_KEYS=2, DEBOUNCE_CYCLES=8.

- **Reset:** assert `reset` for 3 cycles with `key_raw`=2'b00 → during reset `key_clean`=2'b11 and strobes are 0. After release, `key_clean` goes to 2'b00 exactly 10 edges after the first sample. `key_press`=2'b11 for one cycle.
- **Clean press:** `key_raw[0]` goes 1→0 and holds → `key_clean[0]`=0 at sample edge +10. `key_press[0]` is high that cycle only, and `key_release` stays 0.
- **Bounce:** `key_raw[0]` toggles 0/1 every 3 cycles for 30 cycles, then holds 0.
  - `key_clean[0]` stays 1 throughout the bounce.
  - `key_clean[0]` goes to 0 ten edges after the final transition, with one `key_press[0]`.
- **Exact window:**
  - A raw 0-pulse of 7 cycles → no change and no strobe.
  - A raw 0-pulse of 8 cycles → `key_clean[0]` goes low. A `key_release[0]` follows 8 cycles after it returns high.
- **Independence:** key 0 pressed and key 1 released in the same cycle → both update on the same edge. `key_press`=2'b01 and `key_release`=2'b10 for one cycle.
- **Reset mid-count:**
  - Assert `reset` when `cnt[0]`=5 → `cnt` clears and `key_clean` returns to 1.
  - Raw held at 0 → a new full 8-cycle window is required; no early acceptance.
